// File: rtl/nibble_link_receiver.sv
// rtl/nibble_link_receiver.sv - oversampling 4-bit camera link receiver emitting cam0/cam1 pixel pairs
// Optional row/column tagging and frame-size check under NIBBLE_RX_FRAME_CHECK_EN.
module nibble_link_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        link_clk_i,
    input  logic [3:0]  link_data_i,
    input  logic        link_valid_i,
    input  logic        link_sof_i,
    input  logic        link_cam_i,
    output logic [7:0]  pix0_o,
    output logic [7:0]  pix1_o,
    output logic        pair_valid_o,
    output logic        sof_o,
    output logic [15:0] row_o,
    output logic [15:0] col_o,
    output logic        seq_err_o,
    output logic        sof_err_o,
    output logic        frame_err_o
);

    typedef enum logic [1:0] {S0, S1, S2, S3} slot_e;

    // Each stage carries {clk, sof, cam, valid, data} so all link fields stay aligned.
    logic [SYNC_STAGES-1:0][7:0] sync_q;
    logic                        clk_prev_q;
    logic [7:0]                  s_word;
    logic                        s_clk, s_sof, s_cam, s_valid, sample;
    logic [3:0]                  s_data;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync_q     <= '0;
            clk_prev_q <= 1'b0;
        end else begin
            sync_q[0] <= {link_clk_i, link_sof_i, link_cam_i, link_valid_i, link_data_i};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            clk_prev_q <= s_clk;
        end
    end

    assign s_word  = sync_q[SYNC_STAGES-1];
    assign s_clk   = s_word[7];
    assign s_sof   = s_word[6];
    assign s_cam   = s_word[5];
    assign s_valid = s_word[4];
    assign s_data  = s_word[3:0];
    assign sample  = s_clk & ~clk_prev_q;

    slot_e      state_q, state_d;
    logic [3:0] nib0_q, nib0_d, nib1_q, nib1_d, nib2_q, nib2_d;
    logic       sof0_q, sof0_d, sof1_q, sof1_d;
    logic [7:0] pix0_q, pix0_d, pix1_q, pix1_d;
    logic       sof_q, sof_d;
    logic       pair_valid_q, pair_valid_d;
    logic       seq_err_q, seq_err_d;
    logic       sof_err_q, sof_err_d;
    logic       complete;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= S0;
            nib0_q       <= '0;
            nib1_q       <= '0;
            nib2_q       <= '0;
            sof0_q       <= 1'b0;
            sof1_q       <= 1'b0;
            pix0_q       <= '0;
            pix1_q       <= '0;
            sof_q        <= 1'b0;
            pair_valid_q <= 1'b0;
            seq_err_q    <= 1'b0;
            sof_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            nib0_q       <= nib0_d;
            nib1_q       <= nib1_d;
            nib2_q       <= nib2_d;
            sof0_q       <= sof0_d;
            sof1_q       <= sof1_d;
            pix0_q       <= pix0_d;
            pix1_q       <= pix1_d;
            sof_q        <= sof_d;
            pair_valid_q <= pair_valid_d;
            seq_err_q    <= seq_err_d;
            sof_err_q    <= sof_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        nib0_d       = nib0_q;
        nib1_d       = nib1_q;
        nib2_d       = nib2_q;
        sof0_d       = sof0_q;
        sof1_d       = sof1_q;
        pix0_d       = pix0_q;
        pix1_d       = pix1_q;
        sof_d        = sof_q;
        pair_valid_d = 1'b0;
        seq_err_d    = 1'b0;
        sof_err_d    = 1'b0;
        complete     = 1'b0;
        if (sample) begin
            if (!s_valid) begin
                state_d   = S0;
                seq_err_d = (state_q != S0);
            end else if (s_cam == state_q[1]) begin
                case (state_q)
                    S0: begin nib0_d = s_data; sof0_d = s_sof; state_d = S1; end
                    S1: begin nib1_d = s_data; state_d = S2; end
                    S2: begin nib2_d = s_data; sof1_d = s_sof; state_d = S3; end
                    S3: begin state_d = S0; complete = 1'b1; end
                endcase
            end else if (!s_cam) begin
                // Out-of-place cam0 nibble is treated as the start of a fresh group.
                seq_err_d = 1'b1;
                nib0_d    = s_data;
                sof0_d    = s_sof;
                state_d   = S1;
            end else begin
                seq_err_d = 1'b1;
                state_d   = S0;
            end
        end
        if (complete) begin
            pair_valid_d = 1'b1;
            pix0_d       = {nib1_q, nib0_q};
            pix1_d       = {s_data, nib2_q};
            sof_d        = sof0_q;
            sof_err_d    = sof0_q ^ sof1_q;
        end
    end

    assign pix0_o       = pix0_q;
    assign pix1_o       = pix1_q;
    assign sof_o        = sof_q;
    assign pair_valid_o = pair_valid_q;
    assign seq_err_o    = seq_err_q;
    assign sof_err_o    = sof_err_q;

`ifdef NIBBLE_RX_FRAME_CHECK_EN
    localparam logic [15:0] LAST_COL = 16'(IMG_WIDTH - 1);
    localparam logic [15:0] LAST_ROW = 16'(IMG_HEIGHT - 1);

    // row_q/col_q tag the emitted pair; nrow_q/ncol_q hold the position of the next one.
    logic [15:0] row_q, row_d, col_q, col_d, nrow_q, nrow_d, ncol_q, ncol_d;
    logic        seen_q, seen_d, frame_err_q, frame_err_d;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            row_q       <= '0;
            col_q       <= '0;
            nrow_q      <= '0;
            ncol_q      <= '0;
            seen_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            row_q       <= row_d;
            col_q       <= col_d;
            nrow_q      <= nrow_d;
            ncol_q      <= ncol_d;
            seen_q      <= seen_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        row_d       = row_q;
        col_d       = col_q;
        nrow_d      = nrow_q;
        ncol_d      = ncol_q;
        seen_d      = seen_q;
        frame_err_d = 1'b0;
        if (complete) begin
            if (sof0_q) begin
                frame_err_d = seen_q && !(row_q == LAST_ROW && col_q == LAST_COL);
                seen_d      = 1'b1;
                row_d       = '0;
                col_d       = '0;
            end else begin
                row_d = nrow_q;
                col_d = ncol_q;
            end
            if (col_d == LAST_COL) begin
                ncol_d = '0;
                nrow_d = (row_d == 16'hFFFF) ? row_d : row_d + 16'd1;
            end else begin
                ncol_d = col_d + 16'd1;
                nrow_d = row_d;
            end
        end
    end

    assign row_o       = row_q;
    assign col_o       = col_q;
    assign frame_err_o = frame_err_q;
`else
    assign row_o       = '0;
    assign col_o       = '0;
    assign frame_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_link_receiver.sv
// tb/tb_nibble_link_receiver.sv - scoreboard bench for nibble_link_receiver
module tb_nibble_link_receiver;

    localparam int SYNC = 2;
    localparam int TB_W = 4;
    localparam int TB_H = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        link_clk = 1'b0;
    logic [3:0]  link_data = '0;
    logic        link_valid = 1'b0;
    logic        link_sof = 1'b0;
    logic        link_cam = 1'b0;
    logic [7:0]  pix0_o, pix1_o;
    logic        pair_valid_o, sof_o, seq_err_o, sof_err_o, frame_err_o;
    logic [15:0] row_o, col_o;

    nibble_link_receiver #(
        .SYNC_STAGES(SYNC),
        .IMG_WIDTH  (TB_W),
        .IMG_HEIGHT (TB_H)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .link_clk_i  (link_clk),
        .link_data_i (link_data),
        .link_valid_i(link_valid),
        .link_sof_i  (link_sof),
        .link_cam_i  (link_cam),
        .pix0_o      (pix0_o),
        .pix1_o      (pix1_o),
        .pair_valid_o(pair_valid_o),
        .sof_o       (sof_o),
        .row_o       (row_o),
        .col_o       (col_o),
        .seq_err_o   (seq_err_o),
        .sof_err_o   (sof_err_o),
        .frame_err_o (frame_err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  p0;
        logic [7:0]  p1;
        logic        sof;
        logic        sof_err;
        logic        ferr;
        logic [15:0] row;
        logic [15:0] col;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail = 0;
    int   seq_cnt = 0;
    int   ferr_cnt = 0;
    bit   m_seen = 1'b0;
    logic [15:0] m_row = '0, m_col = '0, m_nrow = '0, m_ncol = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (seq_err_o) seq_cnt++;
            if (frame_err_o) ferr_cnt++;
            if (pair_valid_o) begin
                n_assert++;
                assert (exp_q.size() > 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_pair observed pix0=%h pix1=%h required no pair", pix0_o, pix1_o);
                end
                if (exp_q.size() > 0) begin
                    exp_t e, o;
                    e = exp_q.pop_front();
                    o = '{pix0_o, pix1_o, sof_o, sof_err_o, frame_err_o, row_o, col_o};
                    n_assert++;
                    assert (o === e) else begin
                        n_fail++;
                        $error("FAIL pair observed p0=%h p1=%h sof=%b serr=%b ferr=%b row=%0d col=%0d required p0=%h p1=%h sof=%b serr=%b ferr=%b row=%0d col=%0d",
                               o.p0, o.p1, o.sof, o.sof_err, o.ferr, o.row, o.col,
                               e.p0, e.p1, e.sof, e.sof_err, e.ferr, e.row, e.col);
                    end
                end
            end
        end
    end

    task automatic push_exp(input logic [7:0] p0, input logic [7:0] p1, input logic s0, input logic s1);
        exp_t e;
        e = '{p0, p1, s0, s0 ^ s1, 1'b0, 16'd0, 16'd0};
`ifdef NIBBLE_RX_FRAME_CHECK_EN
        if (s0) begin
            e.ferr = m_seen && !(m_row == 16'(TB_H - 1) && m_col == 16'(TB_W - 1));
            m_seen = 1'b1;
        end else begin
            e.row = m_nrow;
            e.col = m_ncol;
        end
        m_row = e.row;
        m_col = e.col;
        if (e.col == 16'(TB_W - 1)) begin
            m_ncol = '0;
            m_nrow = (e.row == 16'hFFFF) ? e.row : e.row + 16'd1;
        end else begin
            m_ncol = e.col + 16'd1;
            m_nrow = e.row;
        end
`endif
        exp_q.push_back(e);
    endtask

    // One link clock period (8 clk cycles): data changes with the fall, rise mid-period.
    task automatic nib(input logic [3:0] d, input logic v, input logic s, input logic c);
        link_clk = 1'b0; link_data = d; link_valid = v; link_sof = s; link_cam = c;
        repeat (4) @(posedge clk);
        #1 link_clk = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic send_group(input logic [7:0] p0, input logic [7:0] p1, input logic s0, input logic s1);
        push_exp(p0, p1, s0, s1);
        nib(p0[3:0], 1'b1, s0, 1'b0);
        nib(p0[7:4], 1'b1, s0, 1'b0);
        nib(p1[3:0], 1'b1, s1, 1'b1);
        nib(p1[7:4], 1'b1, s1, 1'b1);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
        n_assert++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL %s_drain observed %0d pairs missing required 0", tag, exp_q.size());
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic check_int(input string tag, input int obs, input int req);
        n_assert++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s observed %0d required %0d", tag, obs, req);
        end
    endtask

    initial begin
        int base, lat;
        logic [52:0] all_out;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        all_out = {pix0_o, pix1_o, pair_valid_o, sof_o, row_o, col_o, seq_err_o, sof_err_o, frame_err_o};
        n_assert++;
        assert (all_out === 53'd0) else begin
            n_fail++;
            $error("FAIL reset_outputs observed %h required 0", all_out);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        // Single group with latency measurement on the fourth nibble
        base = seq_cnt;
        push_exp(8'hA5, 8'hC3, 1'b1, 1'b1);
        nib(4'h5, 1'b1, 1'b1, 1'b0);
        nib(4'hA, 1'b1, 1'b1, 1'b0);
        nib(4'h3, 1'b1, 1'b1, 1'b1);
        link_clk = 1'b0; link_data = 4'hC; link_valid = 1'b1; link_sof = 1'b1; link_cam = 1'b1;
        repeat (4) @(posedge clk);
        #1 link_clk = 1'b1;
        lat = 99;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (pair_valid_o) begin
                lat = k;
                break;
            end
        end
        n_assert++;
        assert (lat >= SYNC + 1 && lat <= SYNC + 3) else begin
            n_fail++;
            $error("FAIL latency observed %0d required %0d..%0d", lat, SYNC + 1, SYNC + 3);
        end
        drain("single");
        check_int("single_seq_err", seq_cnt - base, 0);

        // Back-to-back groups, long idle, more groups
        base = seq_cnt;
        send_group(8'h12, 8'h34, 1'b0, 1'b0);
        send_group(8'hFE, 8'h01, 1'b0, 1'b0);
        send_group(8'h7C, 8'h8D, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) nib(4'h0, 1'b0, 1'b0, 1'b0);
        send_group(8'h00, 8'hFF, 1'b0, 1'b0);
        send_group(8'h69, 8'h96, 1'b0, 1'b0);
        drain("b2b");
        check_int("b2b_seq_err", seq_cnt - base, 0);

        // Valid drops after third nibble, then a clean group
        base = seq_cnt;
        nib(4'h1, 1'b1, 1'b0, 1'b0);
        nib(4'h2, 1'b1, 1'b0, 1'b0);
        nib(4'h3, 1'b1, 1'b0, 1'b1);
        nib(4'h0, 1'b0, 1'b0, 1'b0);
        send_group(8'hB4, 8'h4B, 1'b0, 1'b0);
        drain("drop");
        check_int("drop_seq_err", seq_cnt - base, 1);

        // Camera SOF disagreement
        base = seq_cnt;
        send_group(8'h5A, 8'hA5, 1'b1, 1'b0);
        drain("sof_mismatch");
        check_int("sof_mismatch_seq_err", seq_cnt - base, 0);

`ifdef NIBBLE_RX_FRAME_CHECK_EN
        send_group(8'h10, 8'h20, 1'b1, 1'b1);
        drain("frame_start");
        base = ferr_cnt;
        for (int i = 1; i < 8; i++) send_group(8'(i), 8'(i + 8'h40), 1'b0, 1'b0);
        send_group(8'h11, 8'h22, 1'b1, 1'b1);
        drain("frame_good");
        check_int("frame_good_ferr", ferr_cnt - base, 0);
        base = ferr_cnt;
        for (int i = 1; i < 7; i++) send_group(8'(i + 8'h80), 8'(i), 1'b0, 1'b0);
        send_group(8'h33, 8'h44, 1'b1, 1'b1);
        drain("frame_short");
        check_int("frame_short_ferr", ferr_cnt - base, 1);
`endif

        // Reset mid-group after the second nibble
        nib(4'h9, 1'b1, 1'b0, 1'b0);
        nib(4'h8, 1'b1, 1'b0, 1'b0);
        link_clk = 1'b0; link_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        all_out = {pix0_o, pix1_o, pair_valid_o, sof_o, row_o, col_o, seq_err_o, sof_err_o, frame_err_o};
        n_assert++;
        assert (all_out === 53'd0) else begin
            n_fail++;
            $error("FAIL midreset_outputs observed %h required 0", all_out);
        end
        m_seen = 1'b0; m_row = '0; m_col = '0; m_nrow = '0; m_ncol = '0;
        base = seq_cnt;
        send_group(8'hC7, 8'h3E, 1'b0, 1'b0);
        drain("after_reset");
        check_int("after_reset_seq_err", seq_cnt - base, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
